// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

  typedef logic [31:0]       word_t;
  typedef logic [15:0][31:0] chunk_t;

  typedef enum logic [1:0] {
    FILL,
    PAD,
    LEN,
    EMIT
  } pad_state_e;

  localparam logic [7:0] PAD_BYTE    = 8'h80;
  localparam int         LEN_WORD_HI = 14;

endpackage

// File: rtl/sha256_pad_word.sv
// Keeps the first nbytes bytes of a big-endian word, places the 0x80 pad byte
// right after them and zeroes the rest. nbytes of 4 or more passes the word through.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] data,
  input  logic [2:0]  nbytes,
  output logic [31:0] padded
);

  logic [31:0] keep_mask;
  logic [31:0] pad_bits;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    keep_mask = 32'hffff_ffff;
    pad_bits  = 32'h0;
    case (nbytes)
      3'd0: begin keep_mask = 32'h0000_0000; pad_bits = {PAD_BYTE, 24'h0}; end
      3'd1: begin keep_mask = 32'hff00_0000; pad_bits = {8'h0, PAD_BYTE, 16'h0}; end
      3'd2: begin keep_mask = 32'hffff_0000; pad_bits = {16'h0, PAD_BYTE, 8'h0}; end
      3'd3: begin keep_mask = 32'hffff_ff00; pad_bits = {24'h0, PAD_BYTE}; end
      default: ;
    endcase
    padded = (data & keep_mask) | pad_bits;
  end

endmodule

// File: rtl/sha256_padder.sv
// Stream-to-chunk SHA-256 padder: packs 32-bit words into 512-bit chunks and appends
// pad byte, zero fill and bit length. Optional SHA256_PAD_LEN_CHECK_EN adds sticky len_err.
module sha256_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_nbytes,
  output logic         chunk_valid,
  input  logic         chunk_ready,
  output logic [511:0] chunk,
  output logic         chunk_first,
  output logic         chunk_last
`ifdef SHA256_PAD_LEN_CHECK_EN
  ,
  output logic         len_err
`endif
);

  localparam logic [3:0] HI_SLOT = 4'(15 - LEN_WORD_HI);
  localparam logic [3:0] LO_SLOT = HI_SLOT - 4'd1;

  pad_state_e       state, state_next;
  chunk_t           blk_q;
  logic [3:0]       idx, tail_idx;
  logic [LEN_W-1:0] bit_len, bit_len_next;
  logic             first_q, last_q, pend_q, padded_q;
  logic [2:0]       last_nb, nb_eff, pw_nb;
  logic [4:0]       pad_pos;
  logic [63:0]      len64;
  logic             accept, pad_in_tail;
  word_t            pw_data, pw_out;

  assign in_ready    = (state == FILL) && !rst;
  assign accept      = in_valid && in_ready;
  assign chunk_valid = (state == EMIT);
  assign chunk_first = chunk_valid && first_q;
  assign chunk_last  = chunk_valid && last_q;
  assign chunk       = blk_q;
  assign len64       = 64'(bit_len);
  assign nb_eff      = (in_last && in_nbytes <= 3'd4) ? in_nbytes : 3'd4;
  assign tail_idx    = idx - 4'd1;

  // A short final word takes the pad itself; a full one pushes it into the next slot
  // (slot 16 means the pad spills into a length-only chunk).
  assign pad_in_tail = (last_nb != 3'd4);
  always_comb begin
    pad_pos = {1'b0, idx};
    if (pad_in_tail)    pad_pos = {1'b0, tail_idx};
    else if (idx == '0) pad_pos = 5'd16;
  end

  assign pw_data = (state == PAD && pad_in_tail) ? blk_q[~tail_idx] : '0;
  assign pw_nb   = (state == PAD && pad_in_tail) ? last_nb : 3'd0;

  sha256_pad_word u_pad_word (
    .data   (pw_data),
    .nbytes (pw_nb),
    .padded (pw_out)
  );

`ifdef SHA256_PAD_LEN_CHECK_EN
  logic len_carry, nb_bad;
  assign {len_carry, bit_len_next} = {1'b0, bit_len} + (LEN_W + 1)'({nb_eff, 3'b000});
  assign nb_bad = (in_nbytes > 3'd4) || (!in_last && in_nbytes == 3'd0);

  always_ff @(posedge clk) begin
    if (rst)                              len_err <= 1'b0;
    else if (accept && (nb_bad || len_carry)) len_err <= 1'b1;
  end
`else
  assign bit_len_next = bit_len + LEN_W'({nb_eff, 3'b000});
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (accept && in_last)          state_next = PAD;
               else if (accept && idx == 4'd15) state_next = EMIT;
      PAD:     state_next = EMIT;
      LEN:     state_next = EMIT;
      EMIT:    if (chunk_ready) state_next = pend_q ? LEN : FILL;
      default: state_next = FILL;
    endcase
  end

  // NOTE: the chunk buffer is reset along with control state, because chunk must read 0 in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q    <= '0;
      idx      <= '0;
      bit_len  <= '0;
      first_q  <= 1'b1;
      last_q   <= 1'b0;
      pend_q   <= 1'b0;
      padded_q <= 1'b0;
      last_nb  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; later ones in the same cycle win.
      case (state)
        FILL: if (accept) begin
          blk_q[~idx] <= in_data;
          idx         <= idx + 4'd1;
          bit_len     <= bit_len_next;
          last_nb     <= nb_eff;
          last_q      <= 1'b0;
        end
        PAD: begin
          for (int w = 0; w < 16; w++) begin
            if (5'(w) == pad_pos)     blk_q[4'(15 - w)] <= pw_out;
            else if (5'(w) > pad_pos) blk_q[4'(15 - w)] <= '0;
          end
          if (pad_pos <= 5'(LEN_WORD_HI - 1)) begin
            blk_q[HI_SLOT] <= len64[63:32];
            blk_q[LO_SLOT] <= len64[31:0];
            last_q         <= 1'b1;
          end else begin
            pend_q   <= 1'b1;
            padded_q <= (pad_pos != 5'd16);
          end
        end
        LEN: begin
          blk_q          <= '0;
          blk_q[15]      <= padded_q ? '0 : pw_out;
          blk_q[HI_SLOT] <= len64[63:32];
          blk_q[LO_SLOT] <= len64[31:0];
          last_q         <= 1'b1;
          pend_q         <= 1'b0;
        end
        EMIT: if (chunk_ready) begin
          first_q <= last_q;
          if (last_q) begin
            bit_len <= '0;
            idx     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench for sha256_padder: a byte-level FIPS 180-4 padding model feeds an
// expected-chunk queue that a free-running monitor drains on every chunk handshake.
module tb_sha256_padder;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [2:0]   in_nbytes = '0;
  logic         chunk_valid;
  logic         chunk_ready = 1'b0;
  logic [511:0] chunk;
  logic         chunk_first;
  logic         chunk_last;

  int   vectors = 0;
  int   miscompares = 0;
  int   hs_count = 0;
  int   ready_mode = 0;  // 0 random, 1 hold low, 2 hold high
  exp_t exp_q[$];

  always #5 clk = ~clk;

  sha256_padder dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_nbytes   (in_nbytes),
    .chunk_valid (chunk_valid),
    .chunk_ready (chunk_ready),
    .chunk       (chunk),
    .chunk_first (chunk_first),
    .chunk_last  (chunk_last)
  );

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s", name);
  endtask

  // Standard SHA-256 padding on a byte list, then split into 64-byte chunks.
  task automatic push_model(input bq_t msg);
    bq_t         p;
    logic [63:0] bits;
    exp_t        e;
    int          nch;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nch = p.size() / 64;
    for (int c = 0; c < nch; c++) begin
      e.data = '0;
      for (int b = 0; b < 64; b++) e.data[511 - 8*b -: 8] = p[c*64 + b];
      e.first = (c == 0);
      e.last  = (c == nch - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic put_word(input logic [31:0] d, input logic l, input logic [2:0] nb);
    bit ok;
    int guard;
    if ($urandom_range(0, 4) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    end
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = l;
    in_nbytes = nb;
    ok = 1'b0;
    guard = 0;
    while (!ok) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      @(posedge clk); #1;
      guard++;
      if (!ok && guard > 3000) begin
        fail("in_ready_timeout");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // tail: 0 random, 1 final full word carries in_last, 2 separate empty tail word
  task automatic send_msg(input bq_t msg, input int tail);
    int          n, nfull, rem;
    logic [31:0] w;
    bit          empty_tail;
    n = msg.size();
    nfull = n / 4;
    rem = n % 4;
    push_model(msg);
    empty_tail = (n == 0) ||
                 (rem == 0 && (tail == 2 || (tail == 0 && $urandom_range(0, 1) == 1)));
    for (int i = 0; i < nfull; i++) begin
      w = {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]};
      if (i == nfull - 1 && rem == 0 && !empty_tail) put_word(w, 1'b1, 3'd4);
      else put_word(w, 1'b0, 3'($urandom_range(0, 7)));
    end
    if (rem != 0 || empty_tail) begin
      w = $urandom();
      for (int b = 0; b < rem; b++) w[31 - 8*b -: 8] = msg[4*nfull + b];
      put_word(w, 1'b1, 3'(rem));
    end
  endtask

  function automatic bq_t rand_msg(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom()));
    return q;
  endfunction

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || chunk_valid) && g < 5000) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 5000) fail("drain_timeout");
  endtask

  initial begin : monitor
    logic [511:0] held_c;
    logic         held_f, held_l;
    bit           have_held;
    exp_t         e;
    have_held = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       chunk_ready = ($urandom_range(0, 3) != 0);
        1:       chunk_ready = 1'b0;
        default: chunk_ready = 1'b1;
      endcase
      if (rst) begin
        have_held = 1'b0;
        continue;
      end
      if (have_held) begin
        check("valid_held", chunk_valid, 1'b1);
        check("chunk_stable", chunk, held_c);
        check("first_stable", chunk_first, held_f);
        check("last_stable", chunk_last, held_l);
      end
      have_held = 1'b0;
      if (chunk_valid) begin
        check("in_ready_low_in_emit", in_ready, 1'b0);
        if (chunk_ready) begin
          hs_count++;
          if (exp_q.size() == 0) fail("unexpected_chunk");
          else begin
            e = exp_q.pop_front();
            check("chunk_data", chunk, e.data);
            check("chunk_first", chunk_first, e.first);
            check("chunk_last", chunk_last, e.last);
          end
        end else begin
          held_c = chunk;
          held_f = chunk_first;
          held_l = chunk_last;
          have_held = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "simulation did not complete");
  end

  initial begin : stimulus
    bq_t  abc, empty_q;
    exp_t e;
    int   hs0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_chunk_valid", chunk_valid, 1'b0);
    check("rst_chunk", chunk, '0);
    check("rst_chunk_first", chunk_first, 1'b0);
    check("rst_chunk_last", chunk_last, 1'b0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready, 1'b1);

    // "abc" against the known FIPS 180-4 block
    e.data  = {32'h61626380, 416'h0, 32'h0, 32'h00000018};
    e.first = 1'b1;
    e.last  = 1'b1;
    exp_q.push_back(e);
    put_word(32'h61626300, 1'b1, 3'd3);
    wait_drain();

    // empty message, with the two-cycle latency after an in_last word
    push_model(empty_q);
    put_word($urandom(), 1'b1, 3'd0);
    check("lat_pad_cycle_valid", chunk_valid, 1'b0);
    @(posedge clk); #1;
    check("lat_last_word_valid", chunk_valid, 1'b1);
    wait_drain();

    send_msg(rand_msg(55), 0);
    send_msg(rand_msg(56), 0);
    send_msg(rand_msg(64), 1);
    send_msg(rand_msg(64), 2);
    send_msg(rand_msg(57), 0);
    send_msg(rand_msg(60), 0);
    send_msg(rand_msg(61), 0);
    send_msg(rand_msg(128), 1);
    wait_drain();

    // backpressure: chunk must hold for 10 cycles, then exactly one handshake
    ready_mode = 1;
    hs0 = hs_count;
    abc = '{8'h61, 8'h62, 8'h63};
    send_msg(abc, 0);
    for (int i = 0; i < 50 && !chunk_valid; i++) begin @(posedge clk); #1; end
    check("bp_valid_seen", chunk_valid, 1'b1);
    repeat (10) begin @(posedge clk); #1; end
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_no_handshake", 32'(hs_count), 32'(hs0));
    ready_mode = 2;
    repeat (3) begin @(posedge clk); #1; end
    check("bp_one_handshake", 32'(hs_count), 32'(hs0 + 1));
    check("bp_valid_dropped", chunk_valid, 1'b0);
    ready_mode = 0;
    wait_drain();

    // reset in the middle of a message discards it
    for (int i = 0; i < 7; i++) put_word($urandom(), 1'b0, 3'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_chunk_valid", chunk_valid, 1'b0);
    check("midrst_chunk", chunk, '0);
    check("midrst_chunk_first", chunk_first, 1'b0);
    check("midrst_chunk_last", chunk_last, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_in_ready_after", in_ready, 1'b1);
    send_msg(abc, 0);
    wait_drain();

    for (int m = 0; m < 30; m++) send_msg(rand_msg($urandom_range(0, 140)), 0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
